// File: rtl/am_sdr_1bit_rx.sv
// 1-bit direct-sampling AM receiver: square-wave quadrature NCO mixer, CIC decimator per
// channel, max+min/2 envelope detector, parallel and PWM audio outputs.
module am_sdr_1bit_rx #(
  parameter int PHASE_W   = 24,
  parameter int CIC_ORDER = 3,
  parameter int DEC_LOG2  = 8,
  parameter int OUT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rf_in,
  input  logic [PHASE_W-1:0] tune_word,
  input  logic               tune_load,
  input  logic               pwm_en,
  output logic [OUT_W-1:0]   mag_out,
  output logic               mag_valid,
  output logic               pwm_out
);

  localparam int N = CIC_ORDER;
  localparam int W = CIC_ORDER * DEC_LOG2 + 2;

  logic [PHASE_W-1:0]  phase, tune_reg;
  logic [DEC_LOG2-1:0] dec_cnt;
  logic [OUT_W-1:0]    pwm_cnt;

  logic [W-1:0] integ_i [N];
  logic [W-1:0] integ_q [N];
  logic [W-1:0] dly_i   [N];
  logic [W-1:0] dly_q   [N];
  logic [W-1:0] comb_i  [N];
  logic [W-1:0] comb_q  [N];
  logic [N-1:0] comb_vld;

  logic [W-2:0] abs_i, abs_q;
  logic         abs_vld;

  logic         lo_i, lo_q, pi, pq, tick;
  logic [W-1:0] x_i, x_q, neg_i, neg_q;
  logic [W-2:0] abs_next_i, abs_next_q, mx, mn, mag_sum;

  assign lo_i = phase[PHASE_W-1];
  assign lo_q = phase[PHASE_W-1] ^ phase[PHASE_W-2];
  assign pi   = rf_in ^ lo_i;
  assign pq   = rf_in ^ lo_q;
  // product bit 0 is +1, 1 is -1
  assign x_i  = pi ? {W{1'b1}} : W'(1);
  assign x_q  = pq ? {W{1'b1}} : W'(1);
  assign tick = (dec_cnt == {DEC_LOG2{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= '0;
      tune_reg <= '0;
      dec_cnt  <= '0;
      pwm_cnt  <= '0;
      pwm_out  <= 1'b0;
    end else begin
      phase   <= phase + tune_reg;
      if (tune_load) tune_reg <= tune_word;
      dec_cnt <= dec_cnt + DEC_LOG2'(1);
      pwm_cnt <= pwm_cnt + OUT_W'(1);
      pwm_out <= pwm_en & (pwm_cnt < mag_out);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        integ_i[k] <= '0;
        integ_q[k] <= '0;
      end
    end else begin
      integ_i[0] <= integ_i[0] + x_i;
      integ_q[0] <= integ_q[0] + x_q;
      for (int k = 1; k < N; k++) begin
        integ_i[k] <= integ_i[k] + integ_i[k-1];
        integ_q[k] <= integ_q[k] + integ_q[k-1];
      end
    end
  end

  // first comb stage consumes the last integrator directly on the tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      comb_vld <= '0;
      for (int k = 0; k < N; k++) begin
        dly_i[k]  <= '0;
        dly_q[k]  <= '0;
        comb_i[k] <= '0;
        comb_q[k] <= '0;
      end
    end else begin
      comb_vld[0] <= tick;
      for (int k = 1; k < N; k++) comb_vld[k] <= comb_vld[k-1];
      if (tick) begin
        comb_i[0] <= integ_i[N-1] - dly_i[0];
        comb_q[0] <= integ_q[N-1] - dly_q[0];
        dly_i[0]  <= integ_i[N-1];
        dly_q[0]  <= integ_q[N-1];
      end
      for (int k = 1; k < N; k++) begin
        if (comb_vld[k-1]) begin
          comb_i[k] <= comb_i[k-1] - dly_i[k];
          comb_q[k] <= comb_q[k-1] - dly_q[k];
          dly_i[k]  <= comb_i[k-1];
          dly_q[k]  <= comb_q[k-1];
        end
      end
    end
  end

  always_comb begin
    neg_i      = -comb_i[N-1];
    neg_q      = -comb_q[N-1];
    abs_next_i = comb_i[N-1][W-1] ? neg_i[W-2:0] : comb_i[N-1][W-2:0];
    abs_next_q = comb_q[N-1][W-1] ? neg_q[W-2:0] : comb_q[N-1][W-2:0];
    if (abs_i >= abs_q) begin
      mx = abs_i;
      mn = abs_q;
    end else begin
      mx = abs_q;
      mn = abs_i;
    end
    mag_sum = mx + (mn >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abs_i     <= '0;
      abs_q     <= '0;
      abs_vld   <= 1'b0;
      mag_out   <= '0;
      mag_valid <= 1'b0;
    end else begin
      abs_vld   <= comb_vld[N-1];
      if (comb_vld[N-1]) begin
        abs_i <= abs_next_i;
        abs_q <= abs_next_q;
      end
      mag_valid <= abs_vld;
      if (abs_vld) mag_out <= mag_sum[W-2 -: OUT_W];
    end
  end

endmodule

// File: tb/tb_am_sdr_1bit_rx.sv
// Directed bench for am_sdr_1bit_rx: vector table of carrier scenarios plus reset and retune sequences.
module tb_am_sdr_1bit_rx;
  localparam int PHASE_W = 24;
  localparam int OUT_W   = 8;

  typedef struct {
    int                 mode;     // 0: rf=0, 1: rf=1, 2: rf follows lo_i, 3: rf toggles
    logic [PHASE_W-1:0] tune;
    logic [OUT_W-1:0]   exp_mag;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rf_in = 1'b0;
  logic tune_load = 1'b0;
  logic pwm_en = 1'b0;
  logic [PHASE_W-1:0] tune_word = '0;
  logic [OUT_W-1:0]   mag_out;
  logic mag_valid, pwm_out;

  int checks = 0;
  int errors = 0;
  int mode = 0;
  logic [PHASE_W-1:0] phase_m, tune_m;
  vec_t vecs [4];

  always #5 clk = ~clk;

  am_sdr_1bit_rx dut (
    .clk(clk), .rst_n(rst_n), .rf_in(rf_in), .tune_word(tune_word),
    .tune_load(tune_load), .pwm_en(pwm_en), .mag_out(mag_out),
    .mag_valid(mag_valid), .pwm_out(pwm_out)
  );

  // reference NCO, used only to generate rf_in aligned with lo_i
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_m <= '0;
      tune_m  <= '0;
    end else begin
      phase_m <= phase_m + tune_m;
      if (tune_load) tune_m <= tune_word;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    tune_load = 1'b0;
    case (mode)
      0: rf_in = 1'b0;
      1: rf_in = 1'b1;
      2: rf_in = phase_m[PHASE_W-1];
      default: rf_in = ~rf_in;
    endcase
  endtask

  task automatic wait_valid(input string name, input int expn);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!mag_valid && n < 600);
    chk(name, n, expn);
  endtask

  task automatic do_reset(input int m, input logic [PHASE_W-1:0] tw);
    rst_n = 1'b0;
    pwm_en = 1'b0;
    tune_load = 1'b0;
    mode = m;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mag_out", mag_out, 0);
    chk("rst_mag_valid", mag_valid, 0);
    chk("rst_pwm_out", pwm_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rf_in = (m == 1);
    tune_word = tw;
    tune_load = 1'b1;
  endtask

  initial begin
    int hi, n;
    // fs/4 with rf=lo_i: I=2^24, Q=0 -> 0x80; DC: |I|=|Q|=2^24 -> 1.5*2^24 -> 0xC0
    vecs[0] = '{0, 24'h000000, 8'hC0};
    vecs[1] = '{1, 24'h000000, 8'hC0};
    vecs[2] = '{2, 24'h400000, 8'h80};
    vecs[3] = '{3, 24'h000000, 8'h00};
    #2;

    for (int v = 0; v < 4; v++) begin
      do_reset(vecs[v].mode, vecs[v].tune);
      wait_valid("first_valid_latency", 260);
      for (int j = 2; j <= 6; j++) begin
        wait_valid("valid_period", 256);
        if (j >= 5) chk($sformatf("mag_vec%0d", v), mag_out, vecs[v].exp_mag);
      end
      pwm_en = 1'b1;
      cyc();
      hi = 0;
      for (int c = 0; c < 256; c++) begin
        cyc();
        hi += int'(pwm_out);
      end
      chk($sformatf("pwm_duty_vec%0d", v), hi, vecs[v].exp_mag);
      if (vecs[v].exp_mag != 0) begin
        n = 0;
        while (!pwm_out && n < 300) begin
          cyc();
          n++;
        end
        chk("pwm_high_seen", pwm_out, 1);
        pwm_en = 1'b0;
        cyc();
        chk("pwm_disable", pwm_out, 0);
      end
    end

    // asynchronous reset landing in a mag_valid cycle
    do_reset(0, '0);
    wait_valid("first_valid_latency", 260);
    for (int j = 2; j <= 6; j++) wait_valid("valid_period", 256);
    chk("pre_rst_valid", mag_valid, 1);
    chk("pre_rst_mag", mag_out, 8'hC0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_mag_out", mag_out, 0);
    chk("async_rst_mag_valid", mag_valid, 0);
    chk("async_rst_pwm_out", pwm_out, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rf_in = 1'b0;
    wait_valid("valid_after_midrun_rst", 260);

    // toggling rf nulls I/Q; retune to fs/2 makes lo_q equal lo_i, so |I|=|Q|=2^24 -> 0xC0
    do_reset(3, '0);
    wait_valid("first_valid_latency", 260);
    for (int j = 2; j <= 5; j++) wait_valid("valid_period", 256);
    chk("alt_null_mag", mag_out, 0);
    tune_word = 24'h800000;
    tune_load = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      wait_valid("retune_period", 256);
      if (j >= 5) chk("retune_mag", mag_out, 8'hC0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
